signal_sync: RTL and testbench
==============================

Name: signal_sync

Overview:
- Brings one asynchronous input into the `clock` domain through a multi-flop synchronizer.
- Emits single-cycle `rising_edge` and `falling_edge` strobes, plus the clean synchronized level.
- Sits at the boundary between external or asynchronous sources (buttons, sensors, encoder lines) and the synchronous rover logic.

Parameters:
- SYNC_STAGES, 2, number of metastability flops in the chain (legal range 2..4).
- RESET_VALUE, 1'b0, level loaded into every synchronizer and history flop on reset.

Ports:
- clock  input  1  system clock; all flops sample on its rising edge.
- reset_n  input  1  asynchronous, active-low reset; release is expected to be synchronous to `clock` upstream.
- asynchronous_signal  input  1  raw input, no timing relationship to `clock`.
- synchronous_signal  output  1  synchronized level (last synchronizer stage).
- rising_edge  output  1  one-cycle strobe on a synchronized 0->1 transition.
- falling_edge  output  1  one-cycle strobe on a synchronized 1->0 transition.

Behaviour:
- Reset: while `reset_n`=0, all sync stages and the history flop = RESET_VALUE, and `rising_edge` = `falling_edge` = 0 immediately (asynchronous).
  - `synchronous_signal` = RESET_VALUE.
  - No strobe is generated on reset release; the history already equals the sync level.
- Sync chain: stage[0] <= `asynchronous_signal`; stage[i] <= stage[i-1]. `synchronous_signal` = stage[SYNC_STAGES-1].
- History: prev <= stage[SYNC_STAGES-1] every clock.
- Strobes are registered:
  - `rising_edge` <= stage[last] & ~prev
  - `falling_edge` <= ~stage[last] & prev
- Latency, SYNC_STAGES=2: an input change first sampled at edge N gives `synchronous_signal` changed after edge N+1. The strobe is high from edge N+2 to edge N+3, i.e. exactly one clock period.
- General latency: strobe asserted SYNC_STAGES edges after the first sampling edge.
- Mutual exclusion: `rising_edge` and `falling_edge` are never high in the same cycle.
- A level held through k>=1 consecutive sampling edges and then reverting produces:
  - a `rising_edge` strobe, then
  - a `falling_edge` strobe exactly k cycles later (k=1 means back-to-back cycles).
- A pulse shorter than one clock period that straddles no rising edge is not seen; no strobe. This is accepted behaviour.
- Input transitioning within a setup/hold window: the resolved value may be either old or new. Strobes must still be consistent with the synchronized level, with at most one-cycle uncertainty.
- Reset asserted mid-operation: strobes clear immediately, including a strobe in progress. After release, the first strobe requires a fresh synchronized change relative to RESET_VALUE.
- No combinational path from `asynchronous_signal` to any output.

Decomposition:
- Shared package holds the `SYNC_STAGES` default and legal-range constants; no typedefs needed.
- One natural sub-module: `sync_chain`, a parameterized N-flop synchronizer with async active-low reset and reset value.
- `signal_sync` instantiates `sync_chain` and adds the history flop and the edge-detect registers.
- Add an elaboration-time check that SYNC_STAGES is within 2..4.

Test Plan:
- Reset hold, 20 ns clock, `reset_n`=0 for 5 cycles, input toggling -> all outputs 0 throughout; after release with input=0, no strobe.
- Single rise: input 0->1 at 5 ns after a rising edge, held 10 cycles -> `synchronous_signal` high after 2nd edge; `rising_edge` high for exactly one 20 ns period starting at 3rd edge; `falling_edge` stays 0.
- Single fall: input 1->0, held -> one `falling_edge` cycle with the same latency; `rising_edge` 0.
- Narrow pulse: input high 8 ns between two rising edges -> no strobe. Input high across exactly one edge -> `rising_edge` then `falling_edge` in consecutive cycles.
- Random toggling: input toggles after uniform 50..150 ns delays for 1000 ns -> strobe count matches synchronized-level transitions; never both strobes high; every strobe one cycle wide.
- Reset mid-strobe: assert `reset_n`=0 during a `rising_edge` cycle -> strobe drops immediately; after release with input still 1, exactly one `rising_edge` after SYNC_STAGES edges.

Source files
------------

// File: rtl/signal_sync_pkg.sv
// signal_sync_pkg: shared constants for the signal_sync synchronizer slice.
// Revision 1.0
`default_nettype none

package signal_sync_pkg;

  localparam int SYNC_STAGES_DEFAULT = 2;
  localparam int SYNC_STAGES_MIN     = 2;
  localparam int SYNC_STAGES_MAX     = 4;

  function automatic bit stages_legal(input int n);
    return (n >= SYNC_STAGES_MIN) && (n <= SYNC_STAGES_MAX);
  endfunction

endpackage

`default_nettype wire

// File: rtl/signal_sync_sync_chain.sv
// sync_chain: N-flop metastability synchronizer with async active-low reset.
// Revision 1.0
`default_nettype none

module sync_chain
  import signal_sync_pkg::*;
#(
  parameter int   STAGES      = SYNC_STAGES_DEFAULT,
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_sync
);

  if (!stages_legal(STAGES)) begin : g_bad_stages
    $error("sync_chain: STAGES must be within 2..4");
  end

  logic [STAGES-1:0] r_stage;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stage <= {STAGES{RESET_VALUE}};
    end else begin
      r_stage <= {r_stage[STAGES-2:0], i_async};
    end
  end

  assign o_sync = r_stage[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/signal_sync.sv
// signal_sync: synchronizes one async input and emits registered edge strobes.
// Revision 1.0
`default_nettype none

module signal_sync
  import signal_sync_pkg::*;
#(
  parameter int   SYNC_STAGES = SYNC_STAGES_DEFAULT,
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic clock,
  input  logic reset_n,
  input  logic asynchronous_signal,
  output logic synchronous_signal,
  output logic rising_edge,
  output logic falling_edge
);

  if (!stages_legal(SYNC_STAGES)) begin : g_bad_stages
    $error("signal_sync: SYNC_STAGES must be within 2..4");
  end

  logic w_sync;
  logic r_prev;
  logic r_rise;
  logic r_fall;

  sync_chain #(
    .STAGES      (SYNC_STAGES),
    .RESET_VALUE (RESET_VALUE)
  ) u_sync_chain (
    .i_clk   (clock),
    .i_rst_n (reset_n),
    .i_async (asynchronous_signal),
    .o_sync  (w_sync)
  );

  // History resets to the same level as the chain so reset release never strobes.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_prev <= RESET_VALUE;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_prev <= w_sync;
      r_rise <= w_sync & ~r_prev;
      r_fall <= ~w_sync & r_prev;
    end
  end

  assign synchronous_signal = w_sync;
  assign rising_edge        = r_rise;
  assign falling_edge       = r_fall;

endmodule

`default_nettype wire

// File: tb/tb_signal_sync.sv
// tb_signal_sync: table vectors, corner sequences and random toggling vs a sample-history model.
// Revision 1.0
`default_nettype none

module tb_signal_sync;

  localparam int   S  = 2;
  localparam logic RV = 1'b0;

  logic clock   = 1'b0;
  logic reset_n = 1'b1;
  logic async_in = 1'b0;
  logic sync_o, rise_o, fall_o;

  signal_sync #(.SYNC_STAGES(S), .RESET_VALUE(RV)) dut (
    .clock               (clock),
    .reset_n             (reset_n),
    .asynchronous_signal (async_in),
    .synchronous_signal  (sync_o),
    .rising_edge         (rise_o),
    .falling_edge        (fall_o)
  );

  always #10 clock = ~clock;  // rising edges at 10, 30, 50 ...

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the effective value sampled at every rising edge (reset counts as RV).
  // Synchronized level lags the sample stream by S-1 edges; strobes by one more.
  logic eff[$];
  bit   chk_en = 0;
  bit   rnd_en = 0;
  int   mdl_r = 0, mdl_f = 0, dut_r = 0, dut_f = 0;
  logic prev_exp = RV;

  always @(posedge clock) eff.push_back(reset_n ? async_in : RV);
  always @(negedge reset_n) foreach (eff[i]) eff[i] = RV;

  function automatic logic m_sync();
    int n = eff.size() - 1;
    return eff[n-(S-1)];
  endfunction
  function automatic logic m_rise();
    int n = eff.size() - 1;
    return eff[n-S] & ~eff[n-S-1];
  endfunction
  function automatic logic m_fall();
    int n = eff.size() - 1;
    return ~eff[n-S] & eff[n-S-1];
  endfunction

  always @(negedge clock) begin
    if (chk_en) begin
      logic es;
      es = m_sync();
      chk("model_sync", sync_o, es);
      chk("model_rise", rise_o, m_rise());
      chk("model_fall", fall_o, m_fall());
      chk("mutex", rise_o & fall_o, 1'b0);
      if (rnd_en) begin
        if (es & ~prev_exp) mdl_r++;
        if (~es & prev_exp) mdl_f++;
        dut_r += int'(rise_o);
        dut_f += int'(fall_o);
      end
      prev_exp = es;
    end
  end

  typedef struct {
    logic in;
    logic s;
    logic r;
    logic f;
  } vec_t;
  vec_t tbl[15];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int first_k;
    int nrise;
    bit seen;

    // Expected state after the edge that first samples each row's input.
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b1};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 1'b1, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b1};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b0};

    for (int i = 0; i < S + 2; i++) eff.push_back(RV);

    // Reset hold with a toggling input.
    #1 reset_n = 1'b0;
    chk_en = 1;
    repeat (5) begin
      @(posedge clock);
      #5 async_in = ~async_in;
      #3 chk("rst_sync", sync_o, RV);
      chk("rst_rise", rise_o, 1'b0);
      chk("rst_fall", fall_o, 1'b0);
      #5 async_in = ~async_in;
    end
    async_in = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    repeat (4) begin
      @(posedge clock);
      #3 chk("release_no_strobe", rise_o | fall_o, 1'b0);
    end

    // Table vectors: single rise, single fall, one-edge pulse.
    @(posedge clock);
    for (int i = 0; i < 15; i++) begin
      #5 async_in = tbl[i].in;
      @(posedge clock);
      #3;
      chk($sformatf("vec%0d_sync", i), sync_o, tbl[i].s);
      chk($sformatf("vec%0d_rise", i), rise_o, tbl[i].r);
      chk($sformatf("vec%0d_fall", i), fall_o, tbl[i].f);
    end

    // Narrow pulse between two rising edges is never sampled.
    @(posedge clock);
    #5 async_in = 1'b1;
    #8 async_in = 1'b0;
    repeat (6) begin
      @(posedge clock);
      #3 chk("narrow_none", rise_o | fall_o | sync_o, 1'b0);
    end

    // Random toggling, input changes kept off the rising edge.
    rnd_en = 1;
    begin
      int t;
      int d;
      t = 0;
      while (t < 1000) begin
        d = $urandom_range(150, 50);
        if ((($time + d) % 20) == 10) d++;
        #d async_in = ~async_in;
        t += d;
      end
    end
    repeat (8) @(posedge clock);
    @(negedge clock);
    #1 rnd_en = 0;
    tests++;
    if (dut_r != mdl_r || dut_f != mdl_f) begin
      fails++;
      $display("FAIL rnd_count: got rise=%0d fall=%0d expected rise=%0d fall=%0d",
               dut_r, dut_f, mdl_r, mdl_f);
    end

    // Reset asserted during a rising strobe.
    async_in = 1'b0;
    repeat (6) @(posedge clock);
    #5 async_in = 1'b1;
    seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clock);
      if (rise_o) seen = 1;
    end
    chk("mid_strobe_seen", seen, 1'b1);
    #2 reset_n = 1'b0;
    #1 chk("mid_strobe_drop", rise_o, 1'b0);
    chk("mid_strobe_sync", sync_o, RV);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    first_k = 0;
    nrise = 0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clock);
      #3;
      if (rise_o) begin
        nrise++;
        if (first_k == 0) first_k = k;
      end
    end
    tests++;
    if (nrise != 1 || first_k != S + 1) begin
      fails++;
      $display("FAIL post_reset_rise: got count=%0d edge=%0d expected count=1 edge=%0d",
               nrise, first_k, S + 1);
    end

    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
